bpf_packet_read_aligner: RTL

//  Sits between the BPF CPU core and the 32-bit-wide packet memory. Turns a CPU byte-addressed load
//  (byte/half/word, any alignment) into one or two word reads, then returns a right-justified,

---
 rtl/bpf_packet_read_aligner_pkg.sv | 27 ++
 rtl/bpf_packet_read_aligner_byte_extract.sv | 26 ++
 rtl/bpf_packet_read_aligner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bpf_packet_read_aligner_pkg.sv
// Shared types for the BPF packet read aligner: load sizes, FSM states and size decoding.
package bpf_packet_read_aligner_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzRsv  = 2'b11
  } xfer_sz_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd0  = 2'b01,
    StRd1  = 2'b10,
    StDone = 2'b11
  } state_e;

  // Reserved size reports 4 bytes; it is rejected as out of bounds regardless.
  function automatic logic [2:0] xfer_nbytes(input xfer_sz_e sz);
    unique case (sz)
      SzByte:  return 3'd1;
      SzHalf:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bpf_packet_read_aligner_byte_extract.sv
// Combinational big-endian byte extractor: picks 1/2/4 bytes starting at offset off of a
// two-word window and returns them right-justified and zero-extended.
module bpf_byte_extract
  import bpf_packet_read_aligner_pkg::*;
(
  input  logic [63:0] cat,
  input  logic [1:0]  off,
  input  xfer_sz_e    size,
  output logic [31:0] result
);

  logic [63:0] sh;

  assign sh = cat << {off, 3'b000};

  always_comb begin
    result = '0;
    unique case (size)
      SzByte:  result = {24'd0, sh[63:56]};
      SzHalf:  result = {16'd0, sh[63:48]};
      SzWord:  result = sh[63:32];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bpf_packet_read_aligner.sv
// Turns CPU byte/half/word packet loads into one or two word reads of a sync-read packet
// memory, bounds-checks them against the packet length and returns a one-cycle result pulse.
module bpf_packet_read_aligner
  import bpf_packet_read_aligner_pkg::*;
#(
  parameter int unsigned PACKET_BYTE_ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_addr,
  input  logic [1:0]                        transfer_sz,
  input  logic [PACKET_BYTE_ADDR_WIDTH:0]   packet_len,
  output logic [31:0]                       resolved_data,
  output logic                              data_ready,
  output logic                              oob,
  output logic                              busy,
  output logic                              mem_rd_en,
  output logic [PACKET_BYTE_ADDR_WIDTH-3:0] mem_rd_addr,
  input  logic [31:0]                       mem_rd_data
);

  localparam int unsigned Pbaw = PACKET_BYTE_ADDR_WIDTH;
  localparam int unsigned Waw  = PACKET_BYTE_ADDR_WIDTH - 2;

  state_e          state_q, state_d;
  logic [1:0]      off_q, off_d;
  xfer_sz_e        size_q, size_d;
  logic            span_q, span_d;
  logic [31:0]     w0_q, w0_d;
  logic [31:0]     resolved_q, resolved_d;
  logic            data_ready_q, data_ready_d;
  logic            oob_q, oob_d;
  logic            mem_rd_en_q, mem_rd_en_d;
  logic [Waw-1:0]  mem_rd_addr_q, mem_rd_addr_d;

  xfer_sz_e        req_sz;
  logic [2:0]      req_nbytes;
  logic [Pbaw:0]   req_end;
  logic [2:0]      req_last;
  logic            req_oob;
  logic [63:0]     ext_cat;
  logic [31:0]     ext_result;

  assign req_sz     = xfer_sz_e'(transfer_sz);
  assign req_nbytes = xfer_nbytes(req_sz);
  assign req_end    = {1'b0, byte_addr} + {{(Pbaw - 2){1'b0}}, req_nbytes};
  assign req_last   = {1'b0, byte_addr[1:0]} + req_nbytes;
  assign req_oob    = (req_sz == SzRsv) || (req_end > packet_len);

  // In RD1 the first word was parked in w0_q while the second arrives from memory.
  assign ext_cat = (state_q == StRd1) ? {w0_q, mem_rd_data} : {mem_rd_data, 32'd0};

  bpf_byte_extract u_extract (
    .cat    (ext_cat),
    .off    (off_q),
    .size   (size_q),
    .result (ext_result)
  );

  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    size_d        = size_q;
    span_d        = span_q;
    w0_d          = w0_q;
    resolved_d    = resolved_q;
    data_ready_d  = 1'b0;
    oob_d         = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (rd_en) begin
          off_d  = byte_addr[1:0];
          size_d = req_sz;
          span_d = req_last > 3'd4;
          if (req_oob) begin
            data_ready_d = 1'b1;
            oob_d        = 1'b1;
            resolved_d   = '0;
            state_d      = StDone;
          end else begin
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = byte_addr[Pbaw-1:2];
            state_d       = StRd0;
          end
        end
      end
      // mem_rd_en_q distinguishes the read-issue cycle from the data-return cycle.
      StRd0: begin
        if (mem_rd_en_q) begin
          if (span_q) begin
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = mem_rd_addr_q + {{(Waw - 1){1'b0}}, 1'b1};
            state_d       = StRd1;
          end
        end else begin
          resolved_d   = ext_result;
          data_ready_d = 1'b1;
          state_d      = StDone;
        end
      end
      StRd1: begin
        if (mem_rd_en_q) begin
          w0_d = mem_rd_data;
        end else begin
          resolved_d   = ext_result;
          data_ready_d = 1'b1;
          state_d      = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      off_q         <= 2'd0;
      size_q        <= SzByte;
      span_q        <= 1'b0;
      w0_q          <= '0;
      resolved_q    <= '0;
      data_ready_q  <= 1'b0;
      oob_q         <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      size_q        <= size_d;
      span_q        <= span_d;
      w0_q          <= w0_d;
      resolved_q    <= resolved_d;
      data_ready_q  <= data_ready_d;
      oob_q         <= oob_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
    end
  end

  assign resolved_data = resolved_q;
  assign data_ready    = data_ready_q;
  assign oob           = oob_q;
  assign busy          = (state_q != StIdle);
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_rd_addr   = mem_rd_addr_q;

endmodule
